fa_serial_seq: RTL and testbench
================================

# fa_serial_seq

Sequencer that performs a WIDTH-bit addition by time-multiplexing a single external 1-bit full-adder cell (ports x, y, cin -> A (sum), cout), one bit per clock, LSB first. It accepts operands through a valid/ready request port and feeds the cell bit by bit. It carries the ripple carry in a register between cycles, assembles the result in a shift register, and returns sum and carry-out through a valid/ready response port. It sits between a requester and the shared full-adder cell.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request operands are valid.
- req_ready  out  1  block can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in for bit 0.
- fa_x  out  1  to cell x: current bit of A.
- fa_y  out  1  to cell y: current bit of B.
- fa_cin  out  1  to cell cin: registered carry.
- fa_sum  in  1  from cell sum output (A).
- fa_cout  in  1  from cell cout.
- rsp_valid  out  1  result is valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WIDTH  sum result.
- rsp_cout  out  1  final carry-out.
- busy  out  1  high in RUN or DONE.

## Operation

- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge, the block loads a_sh<=req_a, b_sh<=req_b, carry<=req_cin, cnt<=0, sum_sh<=0, and moves to RUN.
- RUN: req_ready=0.
  - Cell inputs: fa_x=a_sh[0], fa_y=b_sh[0], fa_cin=carry. The cell is combinational; its outputs are sampled at the same edge.
  - Each edge updates the registers as follows:
    - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}
    - carry<=fa_cout
    - a_sh and b_sh shift right by 1 with zero fill.
    - cnt<=cnt+1
  - When cnt==WIDTH-1 at an edge, the block performs that final bit update and moves to DONE.
- DONE:
  - rsp_valid=1, rsp_sum=sum_sh, rsp_cout=carry.
  - On rsp_ready, the block moves to IDLE. rsp_sum and rsp_cout hold their values until the next request is accepted.
- fa_x, fa_y and fa_cin are 0 in IDLE and DONE.
- cnt width is max(1, clog2(WIDTH)). cnt never exceeds WIDTH-1.
- Arithmetic: {rsp_cout, rsp_sum} = req_a + req_b + req_cin, exact and with no truncation. The result is independent of req_* changes after acceptance.
- req_valid in RUN or DONE is ignored. The block neither stalls nor queues it; the requester holds it until req_ready is seen.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing

- Acceptance edge is E0. RUN spans the cycles after E0 through E_WIDTH.
- rsp_valid rises in the cycle following edge E_WIDTH, which is WIDTH cycles of latency after acceptance.
- Minimum period per operation is WIDTH+2 cycles: 1 IDLE accept cycle, WIDTH RUN cycles, and 1 DONE cycle with rsp_ready already high.
- No combinational path exists from req_valid to req_ready, or from rsp_ready to rsp_valid. Both ready and valid are decoded from registered state.
- The only combinational path is fa_sum/fa_cout (through the external cell) into the register D inputs.
- Reset (rst_n low at an edge), from any state including mid-RUN or DONE:
  - Next state is IDLE and the in-flight operation is discarded.
  - rsp_valid=0 and no response is produced.
- Register values after reset: sum_sh=0, carry=0, cnt=0, a_sh=b_sh=0.
- Output values after reset:
  - req_ready=1 (IDLE).
  - rsp_sum=0, rsp_cout=0.
  - fa_*=0.
  - busy=0.
- rsp_valid stays high until the rsp_ready handshake, with rsp_sum and rsp_cout stable throughout.

## Test plan

- WIDTH=8, a=3, b=5, cin=0 -> rsp_valid exactly 8 cycles after the accept edge; rsp_sum=8, rsp_cout=0.
- a=0xFF, b=0x01, cin=0 -> rsp_sum=0x00, rsp_cout=1. a=0xFF, b=0xFF, cin=1 -> rsp_sum=0xFF, rsp_cout=1.
- Backpressure: rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_sum and rsp_cout stable, req_ready=0 throughout. The handshake then returns to IDLE with req_ready=1 next cycle.
- During RUN, drive req_valid=1 with new operands and toggle req_a/req_b every cycle -> ignored; the result equals the originally accepted operands.
- rst_n low for 1 cycle at RUN bit 3 -> IDLE next cycle, rsp_valid never asserts for that op. A subsequent 0x7F+0x01+0 yields 0x80, cout=0.
- WIDTH=1 and WIDTH=4 builds, exhaustive a, b, cin with a behavioral full-adder cell -> every {rsp_cout, rsp_sum} == a+b+cin. Back-to-back ops with req_valid and rsp_ready tied high complete one per WIDTH+2 cycles.

Source files
------------

// File: rtl/fa_serial_seq.sv
// Bit-serial WIDTH-bit adder sequencer driving one shared external full-adder cell,
// LSB first, with valid/ready request and response ports.
module fa_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Next-state decode and request acceptance.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Insert the cell's sum bit at the MSB; also valid for WIDTH == 1.
  always_comb begin
    sum_shift            = sum_sh >> 1;
    sum_shift[WIDTH-1]   = fa_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand shifters, ripple carry, bit counter and result assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= req_a;
      b_sh   <= req_b;
      sum_sh <= '0;
      carry  <= req_cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_shift;
      carry  <= fa_cout;
      // Return to zero on the last bit so cnt stays within 0..WIDTH-1.
      cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign fa_x      = (state == RUN) & a_sh[0];
  assign fa_y      = (state == RUN) & b_sh[0];
  assign fa_cin    = (state == RUN) & carry;
  // sum_sh and carry are untouched outside RUN, so the response holds until the next accept.
  assign rsp_sum   = sum_sh;
  assign rsp_cout  = carry;

endmodule

// File: tb/tb_fa_serial_seq.sv
// Self-checking bench for fa_serial_seq: WIDTH=8 instance with table, random and corner
// sequences, plus an exhaustive WIDTH=1 instance; both use a behavioural full-adder cell.
module tb_fa_serial_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8 instance
  logic       rst_n, req_valid, req_ready, req_cin;
  logic [7:0] req_a, req_b, rsp_sum;
  logic       fa_x, fa_y, fa_cin, fa_sum, fa_cout;
  logic       rsp_valid, rsp_ready, rsp_cout, busy;

  assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

  fa_serial_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  // WIDTH = 1 instance
  logic v1_req, r1_ready, a1, b1, c1, x1, y1, ci1, s1, co1, v1_rsp, r1_rsp, sum1, cout1, busy1;

  assign s1  = x1 ^ y1 ^ ci1;
  assign co1 = (x1 & y1) | (x1 & ci1) | (y1 & ci1);

  fa_serial_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1_req), .req_ready(r1_ready),
    .req_a(a1), .req_b(b1), .req_cin(c1),
    .fa_x(x1), .fa_y(y1), .fa_cin(ci1), .fa_sum(s1), .fa_cout(co1),
    .rsp_valid(v1_rsp), .rsp_ready(r1_rsp), .rsp_sum(sum1),
    .rsp_cout(cout1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    int         hold;
    bit         tog;
  } vec_t;

  vec_t vecs[8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction on the WIDTH=8 instance.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] exp_sum, input logic exp_cout,
                       input int hold, input bit tog);
    int         lat;
    logic [63:0] mask, part;
    req_a     = a;
    req_b     = b;
    req_cin   = c;
    req_valid = 1'b1;
    lat = 0;
    while (!req_ready && lat < 20) begin
      step;
      lat++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    step;
    if (!tog) req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 12) begin
      chk("req_ready_in_run", req_ready, 0);
      chk("busy_in_run", busy, 1);
      if (lat < 8) begin
        mask = (64'd1 << lat) - 64'd1;
        part = ((64'(a) & mask) + (64'(b) & mask) + 64'(c)) >> lat;
        chk("fa_x_bit", fa_x, 64'(a[lat]));
        chk("fa_y_bit", fa_y, 64'(b[lat]));
        chk("fa_cin_bit", fa_cin, part & 64'd1);
      end
      if (tog) begin
        req_a   = 8'($urandom);
        req_b   = 8'($urandom);
        req_cin = 1'($urandom);
      end
      step;
      lat++;
    end
    req_valid = 1'b0;
    chk("latency", lat, 8);
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid_done", rsp_valid, 1);
      chk("rsp_sum", rsp_sum, exp_sum);
      chk("rsp_cout", rsp_cout, exp_cout);
      chk("req_ready_in_done", req_ready, 0);
      chk("fa_idle_in_done", {fa_x, fa_y, fa_cin}, 0);
      if (i < hold) step;
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
    chk("busy_after_hs", busy, 0);
    chk("rsp_sum_held", rsp_sum, exp_sum);
    chk("rsp_cout_held", rsp_cout, exp_cout);
  endtask

  initial begin
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rc;
    logic       seen;
    int         last, n;

    vecs[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1, 1'b0};
    vecs[3] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 5, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 2, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 8'h00; req_b = 8'h00; req_cin = 1'b0;
    v1_req = 1'b0; r1_rsp = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_sum", rsp_sum, 0);
    chk("reset_rsp_cout", rsp_cout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fa", {fa_x, fa_y, fa_cin}, 0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
            vecs[i].hold, vecs[i].tog);

    // Reset in the middle of RUN discards the operation.
    req_a = 8'h12; req_b = 8'h34; req_cin = 1'b0; req_valid = 1'b1;
    chk("mid_reset_ready", req_ready, 1);
    step;
    req_valid = 1'b0;
    step; step; step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("mid_reset_idle", req_ready, 1);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_sum", rsp_sum, 0);
    chk("mid_reset_cout", rsp_cout, 0);
    chk("mid_reset_fa", {fa_x, fa_y, fa_cin}, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_reset_no_rsp", seen, 0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, 1'b0);

    // Random operands against an arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      do_op(ra, rb, rc, model[7:0], model[8], $urandom_range(0, 3), 1'($urandom));
    end

    // Back-to-back with both handshakes tied high: one result every WIDTH+2 cycles.
    req_a = 8'h21; req_b = 8'h42; req_cin = 1'b1;
    req_valid = 1'b1; rsp_ready = 1'b1;
    last = -1; n = 0;
    for (int t = 0; t < 45; t++) begin
      step;
      if (rsp_valid) begin
        chk("b2b_sum", rsp_sum, 8'h64);
        chk("b2b_cout", rsp_cout, 0);
        if (last >= 0) chk("b2b_period", t - last, 10);
        last = t;
        n++;
      end
    end
    chk("b2b_count_ok", (n >= 4) ? 1 : 0, 1);
    req_valid = 1'b0;
    for (int t = 0; t < 12; t++) step;
    rsp_ready = 1'b0;
    chk("b2b_drained", req_ready, 1);

    // WIDTH = 1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      a1 = i[0]; b1 = i[1]; c1 = i[2];
      v1_req = 1'b1;
      chk("w1_ready", r1_ready, 1);
      step;
      v1_req = 1'b0;
      chk("w1_run_busy", busy1, 1);
      chk("w1_run_no_valid", v1_rsp, 0);
      step;
      chk("w1_valid", v1_rsp, 1);
      chk("w1_result", {cout1, sum1}, 64'(i[0]) + 64'(i[1]) + 64'(i[2]));
      r1_rsp = 1'b1;
      step;
      r1_rsp = 1'b0;
      chk("w1_idle", {v1_rsp, r1_ready}, 2'b01);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
